uart_tx_bridge: RTL and testbench

Byte-stream consumer for the core's simulation/console character port. It accepts one-cycle character strobes (char_in/char_valid) from the memory-mapped UART region and buffers them in a small FIFO. It serializes them onto a standard 8N1 asynchronous TX line, decoupling CPU store rate from line rate. It sits beside the MMU at the board level and drives the physical or simulated UART pin.

---
 rtl/uart_tx_bridge_pkg.sv | 17 +
 rtl/uart_tx_bridge_sync_fifo.sv | 55 +++++
 rtl/uart_tx_bridge.sv | 137 +++++++++++++
 tb/tb_uart_tx_bridge.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_bridge_pkg.sv
// Shared definitions for the console UART transmit path.
// Holds the transmitter state encoding, the 8N1 frame constants and the
// idle line level. Both the TX bridge and any future RX path use it.
package uart_tx_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = DATA_BITS + 2;  // start + data + stop
  localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_tx_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head read.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes pointers)
//   push, wdata     write request and data
//   pop             removes the head entry; ignored when empty
//   rdata           current head entry (valid while !empty)
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
// A push while full is still taken when a pop happens at the same edge,
// because the pop frees the slot the push lands in.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: buffers console characters and sends them as 8N1 serial.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   char_in          character byte, valid with char_valid
//   char_valid       one-cycle write strobe
//   clear_overflow   clears the sticky overflow flag
//   tx               serial line, idle high, LSB first
//   tx_busy          FIFO non-empty or frame in flight
//   fifo_count       characters buffered but not yet started
//   overflow         sticky: a character was dropped on a full FIFO
module uart_tx_bridge
  import uart_tx_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  input  logic                          clear_overflow,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  state_t                 state;
  logic [BW-1:0]          baud;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   head;
  logic                   full, empty;
  logic                   bit_end, frame_end, pop, push_ok, drop, idle_next;
  logic [CW-1:0]          count_n;

  assign bit_end   = (baud == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end;
  // Pop from IDLE or at the last stop-bit cycle: back-to-back frames
  // then follow with no idle gap.
  assign pop       = !empty && ((state == IDLE) || frame_end);
  // Full is judged before this edge's pop, but a simultaneous pop frees a slot.
  assign push_ok   = char_valid && (!full || pop);
  assign drop      = char_valid && !push_ok;
  assign count_n   = fifo_count + CW'(push_ok) - CW'(pop);
  assign idle_next = empty && ((state == IDLE) || frame_end);

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_valid),
    .pop   (pop),
    .wdata (char_in),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= LINE_IDLE;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // A drop at the same edge as a clear keeps the flag set.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;

      tx_busy <= !idle_next || (count_n != '0);

      unique case (state)
        IDLE: begin
          tx <= LINE_IDLE;
          if (!empty) begin
            shift   <= head;
            bit_idx <= '0;
            baud    <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == IDX_LAST) begin
              tx    <= LINE_IDLE;
              state <= STOP;
            end else begin
              // Next bit is shift[1] before the shift lands.
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (!empty) begin
              shift   <= head;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Testbench for uart_tx_bridge (CLKS_PER_BIT=4, FIFO_DEPTH=16).
// A queue-based model tracks pending characters and the position within
// the current frame; the expected line level is derived from the frame
// layout (start, 8 data bits LSB first, stop).
module tb_uart_tx_bridge;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       tx, tx_busy, overflow;
  logic [4:0] fifo_count;

  uart_tx_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .char_in        (char_in),
    .char_valid     (char_valid),
    .clear_overflow (clear_overflow),
    .tx             (tx),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  // reference model state
  logic [7:0] q[$];
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 0;
  int         m_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic m_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit c);
    bit full, pop, drop;
    if (r) begin
      q.delete();
      m_active = 0;
      m_pos = 0;
      m_ovf = 0;
      return;
    end
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && (!m_active || m_pos == FRAME - 1);
    drop = 0;
    if (m_active && m_pos != FRAME - 1) m_pos++;
    else if (pop) begin
      m_cur = q.pop_front();
      m_active = 1;
      m_pos = 0;
      m_frames++;
    end else m_active = 0;
    if (v) begin
      if (!full || pop) q.push_back(d);
      else begin
        drop = 1;
        m_ovf = 1;
      end
    end
    if (c && !drop) m_ovf = 0;
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
    rst = r;
    char_valid = v;
    char_in = d;
    clear_overflow = c;
    @(posedge clk);
    model_edge(r, v, d, c);
    #1;
    chk("tx", tx, m_tx());
    chk("tx_busy", tx_busy, m_active || q.size() != 0);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  initial begin
    // reset state
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("reset_tx", tx, 1);
    chk("reset_count", fifo_count, 0);

    // 1: single character, latency and frame length
    step(0, 1, 8'h55, 0);
    step(0, 0, 8'h00, 0);
    chk("t1_start_at_E1", tx, 0);
    chk("t1_count_E1", fifo_count, 0);
    idle(45);
    chk("t1_busy_done", tx_busy, 0);

    // 2: back-to-back frames
    step(0, 1, 8'h41, 0);
    step(0, 1, 8'h42, 0);
    step(0, 1, 8'h43, 0);
    idle(125);
    chk("t2_frames", m_frames, 4);

    // 3: overflow, 18th character dropped (X data is harmless)
    for (int i = 0; i < 17; i++) step(0, 1, 8'($urandom), 0);
    chk("t3_count_full", fifo_count, 16);
    step(0, 1, 8'hxx, 0);
    chk("t3_overflow", overflow, 1);
    idle(17 * FRAME + 10);
    chk("t3_frames", m_frames, 4 + 17);
    chk("t3_idle", tx_busy, 0);

    // 4: clear/drop race
    step(0, 0, 8'h00, 1);
    chk("t4_cleared", overflow, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 8'($urandom), 0);
    step(0, 1, 8'hA5, 1);
    chk("t4_race_set_wins", overflow, 1);
    step(0, 0, 8'h00, 1);
    chk("t4_clear_alone", overflow, 0);
    idle(17 * FRAME + 10);

    // 5: reset during data bit 3 of the first frame
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'hFF, 0);
    idle(17);
    chk("t5_in_bit3", m_pos / CPB, 4);
    step(1, 0, 8'h00, 0);
    chk("t5_tx", tx, 1);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", tx_busy, 0);
    idle(2 * FRAME);

    // 6: push while full at a stop-end edge
    for (int i = 0; i < 17; i++) step(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == FRAME - 1); i++) idle(1);
    chk("t6_found_stop_end", m_active && m_pos == FRAME - 1, 1);
    chk("t6_full_before", fifo_count, 16);
    step(0, 1, 8'h3C, 0);
    chk("t6_count_held", fifo_count, 16);
    chk("t6_no_overflow", overflow, 0);
    idle(17 * FRAME + 10);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
    idle(17 * FRAME + 10);
    chk("final_idle", tx_busy, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
